// File: rtl/sqrt2_pkg.sv
// Shared types and constants for the sqrt2 bus-side host controller.
//   sqrt2_host_state_t : controller state encoding
//   FP16_*             : half-precision special values used around sqrt2
//   DEF_*              : default values for the host parameters
package sqrt2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } sqrt2_host_state_t;

    localparam logic [15:0] FP16_QNAN  = 16'hFE00;
    localparam logic [15:0] FP16_PINF  = 16'h7C00;
    localparam logic [15:0] FP16_NZERO = 16'h8000;

    localparam int DEF_LOAD_CYCLES = 2;
    localparam int DEF_TIMEOUT     = 100;
    localparam int DEF_GAP_CYCLES  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sqrt2_bus_pad.sv
// Registered 16-bit tristate driver for the shared sqrt2 data bus.
//   clk, rst     : clock and synchronous active-high reset (clears the drive enable)
//   load         : capture load_data and start driving on the next edge
//   release_bus  : stop driving on the next edge
//   load_data    : operand to place on the bus
//   io           : shared bus; driven only while the registered enable is set
module sqrt2_bus_pad (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        release_bus,
    input  logic [15:0] load_data,
    inout  wire  [15:0] io
);

    logic [15:0] q;
    logic        oe;

    // The enable is a flop so nothing combinational reaches the tristate control.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe <= 1'b0;
        end else if (load) begin
            oe <= 1'b1;
        end else if (release_bus) begin
            oe <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            q <= load_data;
        end
    end

    assign io = oe ? q : 16'bz;

endmodule

// File: rtl/sqrt2_host.sv
// Bus-side controller for one sqrt2 half-precision square-root unit.
// Accepts an FP16 operand on a valid/ready request port, drives it onto the
// shared IO_DATA bus with ENABLE high for LOAD_CYCLES edges, releases the bus,
// waits for RESULT (or times out) and holds the captured root and flags in a
// response register until consumed.
//   CLK, RESET                 : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY/REQ_DATA : operand request port
//   RSP_VALID/RSP_READY/RSP_DATA : response port (held until consumed)
//   RSP_NAN/RSP_PINF/RSP_NINF  : captured sqrt2 flags
//   RSP_TIMEOUT                : response produced by the WAIT timeout
//   IO_DATA, ENABLE            : shared bus and enable toward sqrt2
//   RESULT, IS_NAN/IS_PINF/IS_NINF : status from sqrt2
module sqrt2_host
    import sqrt2_pkg::*;
#(
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [15:0] REQ_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_DATA,
    output logic        RSP_NAN,
    output logic        RSP_PINF,
    output logic        RSP_NINF,
    output logic        RSP_TIMEOUT,
    inout  wire  [15:0] IO_DATA,
    output logic        ENABLE,
    input  logic        RESULT,
    input  logic        IS_NAN,
    input  logic        IS_PINF,
    input  logic        IS_NINF
);

    // One counter times LOAD, WAIT and GAP, so it is sized for the largest.
    localparam int CNT_MAX = max_int(max_int(TIMEOUT, LOAD_CYCLES), GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    sqrt2_host_state_t state;
    logic [CNT_W-1:0]  cnt;
    logic              enable_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_data_q;
    logic              rsp_nan_q;
    logic              rsp_pinf_q;
    logic              rsp_ninf_q;
    logic              rsp_timeout_q;

    logic accept;
    logic load_done;

    assign REQ_READY = (state == ST_IDLE) && !rsp_valid_q;
    assign accept    = REQ_VALID && REQ_READY;
    assign load_done = (state == ST_LOAD) && (cnt == LOAD_LAST);

    sqrt2_bus_pad u_pad (
        .clk         (CLK),
        .rst         (RESET),
        .load        (accept),
        .release_bus (load_done),
        .load_data   (REQ_DATA),
        .io          (IO_DATA)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            enable_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_nan_q     <= 1'b0;
            rsp_pinf_q    <= 1'b0;
            rsp_ninf_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // Consumption can land in any state; a new response is only
            // produced in WAIT, which cannot be reached while one is pending.
            if (rsp_valid_q && RSP_READY) begin
                rsp_valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        enable_q <= 1'b1;
                        cnt      <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // RESULT is deliberately ignored while the operand is on the bus.
                    if (cnt == LOAD_LAST) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_WAIT: begin
                    // RESULT is checked first so it wins over a coincident timeout.
                    if (RESULT) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= IO_DATA;
                        rsp_nan_q     <= IS_NAN;
                        rsp_pinf_q    <= IS_PINF;
                        rsp_ninf_q    <= IS_NINF;
                        rsp_timeout_q <= 1'b0;
                        state         <= ST_HOLD;
                    end else if (cnt == TO_LAST) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= 16'h0000;
                        rsp_nan_q     <= 1'b0;
                        rsp_pinf_q    <= 1'b0;
                        rsp_ninf_q    <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        cnt           <= sat_inc(cnt);
                        state         <= ST_HOLD;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                ST_HOLD: begin
                    enable_q <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: begin
                    enable_q <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ENABLE      = enable_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_NAN     = rsp_nan_q;
    assign RSP_PINF    = rsp_pinf_q;
    assign RSP_NINF    = rsp_ninf_q;
    assign RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_sqrt2_host.sv
// Self-checking bench for sqrt2_host with a behavioural sqrt2 stand-in.
module tb_sqrt2_host;
    import sqrt2_pkg::*;

    localparam int L = 2;
    localparam int T = 100;
    localparam int G = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [15:0] REQ_DATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [15:0] RSP_DATA;
    logic        RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT;
    wire  [15:0] IO_DATA;
    logic        ENABLE;
    logic        RESULT;
    logic        m_nan, m_pinf, m_ninf;

    // sqrt2 stand-in state
    logic        m_drv;
    logic [15:0] m_q;
    logic [15:0] m_op;
    logic        m_res;
    logic        f_res;
    int          m_cnt;
    int          dly;
    bit          mute;
    bit          early;

    int n_cmp  = 0;
    int n_fail = 0;

    // random-phase scoreboard
    bit          rnd_mode;
    bit          acc_seen;
    int          rcvd;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] op;
        logic [15:0] data;
        logic        nan;
        logic        pinf;
        logic        ninf;
    } vec_t;
    vec_t tv[7];

    assign IO_DATA = m_drv ? m_q : 16'bz;
    assign RESULT  = m_res | f_res;

    always #5 CLK = ~CLK;

    sqrt2_host #(.LOAD_CYCLES(L), .TIMEOUT(T), .GAP_CYCLES(G)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .RSP_NAN(RSP_NAN), .RSP_PINF(RSP_PINF), .RSP_NINF(RSP_NINF),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .IO_DATA(IO_DATA), .ENABLE(ENABLE),
        .RESULT(RESULT), .IS_NAN(m_nan), .IS_PINF(m_pinf), .IS_NINF(m_ninf)
    );

    // ---------------- reference arithmetic ----------------
    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) begin
            v = real'(h[9:0]);
            for (int i = 0; i < 24; i++) v = v / 2.0;
        end else begin
            v = 1.0 + real'(h[9:0]) / 1024.0;
            for (int i = 15; i < e; i++) v = v * 2.0;
            for (int i = e; i < 15; i++) v = v / 2.0;
        end
        return v;
    endfunction

    function automatic logic [15:0] r2h_pos(input real x);
        real v;
        int  e;
        int  m;
        logic [4:0] eb;
        logic [9:0] mb;
        v = x;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        m = $rtoi($floor((v - 1.0) * 1024.0 + 0.5));
        if (m == 1024) begin m = 0; e++; end
        eb = 5'(e);
        mb = 10'(m);
        return {1'b0, eb, mb};
    endfunction

    // {nan, pinf, ninf, root}
    function automatic logic [18:0] ref_sqrt(input logic [15:0] h);
        if (h[14:10] == 5'h1F && h[9:0] != 10'd0) return {3'b100, FP16_QNAN};
        if (h == FP16_PINF)                       return {3'b010, FP16_PINF};
        if (h == 16'h0000)                        return {3'b000, 16'h0000};
        if (h == FP16_NZERO)                      return {3'b000, FP16_NZERO};
        if (h[15])                                return {3'b100, FP16_QNAN};
        return {3'b000, r2h_pos($sqrt(h2r(h)))};
    endfunction

    // ---------------- behavioural sqrt2 ----------------
    always @(posedge CLK) begin
        if (!ENABLE) begin
            m_cnt  <= 0;
            m_drv  <= 1'b0;
            m_res  <= 1'b0;
            m_nan  <= 1'b0;
            m_pinf <= 1'b0;
            m_ninf <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
            m_res <= 1'b0;
            if (m_cnt == 0) begin
                m_op <= IO_DATA;
                if (early) m_res <= 1'b1;
            end
            if (m_cnt == dly && m_cnt != 0 && !mute) begin
                {m_nan, m_pinf, m_ninf, m_q} <= ref_sqrt(m_op);
                m_drv <= 1'b1;
                m_res <= 1'b1;
            end
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: monitor at the falling edge, return #1 after the rising edge.
    task automatic cycle();
        logic [18:0] e;
        @(negedge CLK);
        chk1("bus_contention", dut.u_pad.oe && m_drv, 1'b0);
        if (rnd_mode) begin
            if (REQ_VALID && REQ_READY) begin
                exp_q.push_back(REQ_DATA);
                acc_seen = 1'b1;
            end
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) begin
                    chk1("rnd_unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    e = ref_sqrt(exp_q.pop_front());
                    chk16("rnd_data", RSP_DATA, e[15:0]);
                    chk1("rnd_nan", RSP_NAN, e[18]);
                    chk1("rnd_pinf", RSP_PINF, e[17]);
                    chk1("rnd_timeout", RSP_TIMEOUT, 1'b0);
                end
                rcvd++;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] op);
        int n;
        n = 0;
        while (!REQ_READY && n < 500) begin cycle(); n++; end
        if (!REQ_READY) chk1("req_ready_wait", REQ_READY, 1'b1);
        REQ_VALID = 1'b1;
        REQ_DATA  = op;
        cycle();
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_rsp(output int k);
        k = 0;
        while (!RSP_VALID && k < 300) begin cycle(); k++; end
        if (!RSP_VALID) chk1("rsp_valid_wait", RSP_VALID, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!REQ_READY && n < 500) begin cycle(); n++; end
        if (!REQ_READY) chk1("drain_wait", REQ_READY, 1'b1);
    endtask

    initial begin
        int          k;
        int          sent;
        logic [4:0]  re;
        logic [9:0]  rm;

        tv[0] = '{16'h4400, 16'h4000, 1'b0, 1'b0, 1'b0};
        tv[1] = '{16'h7C00, 16'h7C00, 1'b0, 1'b1, 1'b0};
        tv[2] = '{16'hFC00, 16'hFE00, 1'b1, 1'b0, 1'b0};
        tv[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0};
        tv[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tv[5] = '{16'h7E00, 16'hFE00, 1'b1, 1'b0, 1'b0};
        tv[6] = '{16'h5400, 16'h4800, 1'b0, 1'b0, 1'b0};

        RESET = 1'b1; REQ_VALID = 1'b0; REQ_DATA = '0; RSP_READY = 1'b0;
        f_res = 1'b0; dly = 1; mute = 1'b0; early = 1'b0;
        rnd_mode = 1'b0; acc_seen = 1'b0; rcvd = 0;
        cycle(); cycle();

        // Reset values
        chk1("rst_enable", ENABLE, 1'b0);
        chk1("rst_drive", dut.u_pad.oe, 1'b0);
        chk1("rst_rsp_valid", RSP_VALID, 1'b0);
        chk16("rst_rsp_data", RSP_DATA, 16'h0000);
        chk1("rst_nan", RSP_NAN, 1'b0);
        chk1("rst_timeout", RSP_TIMEOUT, 1'b0);
        chk1("rst_req_ready", REQ_READY, 1'b1);
        RESET = 1'b0;
        RSP_READY = 1'b1;

        // Detailed timing of one minimum-latency transaction plus back-to-back accept
        send(16'h4400);
        chk1("e0_enable", ENABLE, 1'b1);
        chk1("e0_drive", dut.u_pad.oe, 1'b1);
        chk16("e0_bus", IO_DATA, 16'h4400);
        chk1("e0_req_ready", REQ_READY, 1'b0);
        cycle();
        chk1("e1_drive", dut.u_pad.oe, 1'b1);
        chk16("e1_bus", IO_DATA, 16'h4400);
        cycle();
        chk1("e2_released", dut.u_pad.oe, 1'b0);
        chk16("e2_bus_from_sqrt2", IO_DATA, 16'h4000);
        chk1("e2_rsp_valid", RSP_VALID, 1'b0);
        cycle();
        chk1("e3_rsp_valid", RSP_VALID, 1'b1);
        chk16("e3_rsp_data", RSP_DATA, 16'h4000);
        chk1("e3_timeout", RSP_TIMEOUT, 1'b0);
        chk1("e3_enable_hold", ENABLE, 1'b1);
        cycle();
        chk1("e4_rsp_consumed", RSP_VALID, 1'b0);
        chk1("e4_enable_gap", ENABLE, 1'b0);
        cycle();
        chk1("e5_enable_gap", ENABLE, 1'b0);
        chk1("e5_req_ready", REQ_READY, 1'b0);
        cycle();
        chk1("e6_req_ready", REQ_READY, 1'b1);
        REQ_VALID = 1'b1; REQ_DATA = 16'h4400;
        cycle();
        REQ_VALID = 1'b0;
        chk1("b2b_accept_e7", ENABLE, 1'b1);
        wait_rsp(k);
        drain();

        // Table of operands, including FP16 special values
        for (int i = 0; i < 7; i++) begin
            send(tv[i].op);
            wait_rsp(k);
            n_cmp++;
            if (k != L + 1) begin
                n_fail++;
                $display("FAIL tbl_latency[%0d]: got %0d edges, expected %0d", i, k, L + 1);
            end
            chk16($sformatf("tbl_data[%0d]", i), RSP_DATA, tv[i].data);
            chk1($sformatf("tbl_nan[%0d]", i), RSP_NAN, tv[i].nan);
            chk1($sformatf("tbl_pinf[%0d]", i), RSP_PINF, tv[i].pinf);
            chk1($sformatf("tbl_ninf[%0d]", i), RSP_NINF, tv[i].ninf);
            chk1($sformatf("tbl_timeout[%0d]", i), RSP_TIMEOUT, 1'b0);
            drain();
        end

        // Timeout: sqrt2 never answers
        mute = 1'b1;
        send(16'h4400);
        for (int i = 0; i < L + T - 1; i++) cycle();
        chk1("to_not_yet", RSP_VALID, 1'b0);
        cycle();
        chk1("to_rsp_valid", RSP_VALID, 1'b1);
        chk1("to_flag", RSP_TIMEOUT, 1'b1);
        chk16("to_data", RSP_DATA, 16'h0000);
        chk1("to_nan", RSP_NAN, 1'b0);
        chk1("to_enable_hold", ENABLE, 1'b1);
        cycle();
        chk1("to_enable_drop", ENABLE, 1'b0);
        mute = 1'b0;
        drain();

        // RESULT on the same edge the counter reaches TIMEOUT
        dly = L + T - 2;
        send(16'h4400);
        for (int i = 0; i < L + T - 1; i++) cycle();
        chk1("tie_not_yet", RSP_VALID, 1'b0);
        cycle();
        chk1("tie_rsp_valid", RSP_VALID, 1'b1);
        chk1("tie_timeout", RSP_TIMEOUT, 1'b0);
        chk16("tie_data", RSP_DATA, 16'h4000);
        dly = 1;
        drain();

        // Response held while not consumed; no new accept meanwhile
        RSP_READY = 1'b0;
        send(16'h5400);
        wait_rsp(k);
        chk16("hold_data", RSP_DATA, 16'h4800);
        REQ_VALID = 1'b1; REQ_DATA = 16'h3C00;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk1("hold_valid", RSP_VALID, 1'b1);
            chk16("hold_stable", RSP_DATA, 16'h4800);
            chk1("hold_req_ready", REQ_READY, 1'b0);
        end
        chk1("hold_no_accept", ENABLE, 1'b0);
        RSP_READY = 1'b1;
        cycle();
        RSP_READY = 1'b0;
        chk1("hold_consumed", RSP_VALID, 1'b0);
        chk1("hold_ready_again", REQ_READY, 1'b1);
        cycle();
        REQ_VALID = 1'b0;
        chk1("hold_next_accept", ENABLE, 1'b1);
        RSP_READY = 1'b1;
        wait_rsp(k);
        chk16("hold_next_data", RSP_DATA, 16'h3C00);
        drain();

        // Reset in WAIT discards the transaction
        dly = 20;
        send(16'h4400);
        for (int i = 0; i < 4; i++) cycle();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        dly = 1;
        chk1("mrst_enable", ENABLE, 1'b0);
        chk1("mrst_drive", dut.u_pad.oe, 1'b0);
        chk1("mrst_rsp_valid", RSP_VALID, 1'b0);
        chk1("mrst_req_ready", REQ_READY, 1'b1);
        f_res = 1'b1;
        cycle();
        f_res = 1'b0;
        cycle();
        chk1("mrst_late_result", RSP_VALID, 1'b0);
        chk1("mrst_late_enable", ENABLE, 1'b0);
        send(16'h3C00);
        wait_rsp(k);
        chk16("mrst_fresh_data", RSP_DATA, 16'h3C00);
        drain();

        // Random positive normals with random consumer back-pressure
        rnd_mode = 1'b1;
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 4000 && rcvd < 16; c++) begin
            RSP_READY = 1'($urandom_range(0, 1));
            if (!REQ_VALID && sent < 16 && REQ_READY) begin
                dly   = $urandom_range(L - 1, L + 6);
                early = 1'($urandom_range(0, 1));
                re    = 5'($urandom_range(1, 30));
                rm    = 10'($urandom_range(0, 1023));
                REQ_DATA  = {1'b0, re, rm};
                REQ_VALID = 1'b1;
            end
            cycle();
            if (acc_seen) begin
                REQ_VALID = 1'b0;
                acc_seen  = 1'b0;
                sent++;
            end
        end
        n_cmp++;
        if (rcvd != 16) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d responses, expected 16", rcvd);
        end
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
